branch_hazard_ctrl: RTL and testbench
=====================================

// Module: branch_hazard_ctrl
// PURPOSE
//  Pipeline stall/flush sequencer for the 5-stage RV32I core with branches resolved in ID.
//  - Detects data hazards that ID-stage forwarding (EX/MEM, MEM/WB) cannot cover.
//  - Freezes PC and IF/ID, and injects bubbles into ID/EX for the required cycles.
//  - Flushes IF/ID when a branch or jump in ID is taken.
//  - Keeps saturating performance counters for stall cycles and flushes.
// PARAMETERS
//  CNT_W          32  width of each performance counter
//  LOAD_BR_STALL  2   stall cycles for a branch/JALR in ID reading a load rd in EX (1..3)
// PORTS
//  clk            in   1   core clock; all state updates on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  id_inst        in   32  instruction in IF/ID
//  ex_inst        in   32  instruction in ID/EX
//  mem_inst       in   32  instruction in EX/MEM
//  id_valid       in   1   id_inst is a real instruction (not a bubble)
//  br_taken       in   1   ID comparator result: branch/JAL/JALR in ID redirects PC
//  pc_we          out  1   PC write enable
//  ifid_we        out  1   IF/ID register write enable
//  ifid_flush     out  1   clear IF/ID to NOP on next edge
//  idex_bubble    out  1   load NOP into ID/EX on next edge
//  stall_cnt      out  CNT_W  cycles with pc_we=0 since reset, saturating
//  flush_cnt      out  CNT_W  ifid_flush pulses since reset, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - State is RUN, remaining=0, counters=0.
//   - pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1.
//  Hazard requirement need[1:0], evaluated in RUN only, only when id_valid=1:
//   - A source counts only if rs!=x0.
//   - rs1 is used by R/B/S/I/L/JALR; rs2 is used by R/B/S.
//   - rd is written by R/I/L/JAL/JALR/LUI/AUIPC.
//   - ID is B or JALR and a source == rd of a load in EX: need=LOAD_BR_STALL.
//   - ID is B or JALR and a source == rd of an ALU-writer in EX: need=1.
//   - ID is B or JALR and a source == rd of a load in MEM: need=1.
//   - ID is any other instruction and a source == rd of a load in EX: need=1.
//   - Otherwise need=0. When several rules match, the maximum wins.
//  FSM:
//   - RUN, need=0:
//     - pc_we=1, ifid_we=1, idex_bubble=0.
//     - ifid_flush = br_taken & id_valid & (ID is B, JAL or JALR).
//   - RUN, need>0:
//     - pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0.
//     - remaining<=need-1; next state is STALL if need>1, else RUN.
//   - STALL:
//     - pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0.
//     - remaining decrements each cycle; leave to RUN when remaining==1 at the edge.
//     - br_taken is ignored.
//  Returning to RUN re-evaluates the hazard, so residual dependencies stall again.
//  Simultaneous events: a stall has priority over flush. A taken branch is acted on
//   only in the cycle it is unstalled.
//  Stall latency is exactly `need` cycles from detection. Flush is a 1-cycle pulse in
//   the same cycle the branch leaves ID.
//  Counters:
//   - stall_cnt +1 on every cycle where pc_we=0 and rst_n=1.
//   - flush_cnt +1 on every cycle where ifid_flush=1.
//   - Both hold at all-ones.
//  Reset asserted mid-stall aborts the stall immediately; no pending state survives.
//  Unknown opcodes read no sources and write no rd.
// STRUCTURE
//  - riscv_pkg: opcode constants (R, B, S, I, L, JAL, JALR, LUI, AUIPC), the FSM
//    state enum {RUN, STALL}, and functions uses_rs1/uses_rs2/writes_rd(opcode).
//  - One combinational sub-module, branch_dep_detect, takes (id_inst, ex_inst,
//    mem_inst, id_valid) and produces need[1:0].
//  - The FSM, remaining counter, outputs and performance counters live here.
// TESTING
//  1. Hold rst_n=0 -> pc_we=0, ifid_we=0, idex_bubble=1, both counters 0.
//     Release -> RUN with pc_we=1.
//  2. ex_inst=0x0000A283 (lw x5), id_inst=0x00628063 (beq x5,x6), br_taken=0 ->
//     pc_we=0 for exactly 2 cycles, then 1; stall_cnt=2.
//  3. ex_inst=0x003102B3 (add x5), id_inst=0x00628063 ->
//     exactly 1 stall cycle, then RUN, no flush.
//  4. ex_inst=0x0000A283, id_inst=0x00528333 (add x6,x5,x5) ->
//     1 stall cycle; rs=x0 variant (lw x0) -> no stall.
//  5. id_inst=0x00628063, no hazard, br_taken=1 -> ifid_flush=1 for one cycle,
//     flush_cnt=1. Same case with a load hazard -> flush only after the 2 stall cycles.
//  6. Drop rst_n during the 2nd stall cycle -> outputs take reset values asynchronously.
//     Counters preloaded to all-ones stay saturated.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants, sequencer state type and operand-usage decode
// for the branch hazard controller.
package riscv_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_e;

   function automatic logic uses_rs1(input logic [6:0] op);
      case (op)
         OP_R, OP_B, OP_S, OP_I, OP_L, OP_JALR: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      case (op)
         OP_R, OP_B, OP_S: return 1'b1;
         default:          return 1'b0;
      endcase
   endfunction

   function automatic logic writes_rd(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_L, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
         default:                                             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/branch_hazard_ctrl_branch_dep_detect.sv
// Combinational hazard classifier: how many stall cycles the instruction in ID
// needs before its operands can be forwarded from EX/MEM or MEM/WB.
module branch_dep_detect
   import riscv_pkg::*;
#(
   parameter int unsigned LOAD_BR_STALL = 2
) (
   input  logic [31:0] id_inst,
   input  logic [31:0] ex_inst,
   input  logic [31:0] mem_inst,
   input  logic        id_valid,
   output logic [1:0]  need
);

   logic [6:0] id_op, ex_op, mem_op;
   logic [4:0] rs1, rs2, ex_rd, mem_rd;
   logic       id_br, src1, src2, ex_wr, ex_load, mem_load;
   logic       hit_ex, hit_mem;

   always_comb begin
      id_op    = id_inst[6:0];
      ex_op    = ex_inst[6:0];
      mem_op   = mem_inst[6:0];
      rs1      = id_inst[19:15];
      rs2      = id_inst[24:20];
      ex_rd    = ex_inst[11:7];
      mem_rd   = mem_inst[11:7];

      // Branches and JALR compare in ID, so they need operands a stage earlier.
      id_br    = (id_op == OP_B) || (id_op == OP_JALR);
      src1     = uses_rs1(id_op) && (rs1 != 5'd0);
      src2     = uses_rs2(id_op) && (rs2 != 5'd0);
      ex_wr    = writes_rd(ex_op);
      ex_load  = (ex_op == OP_L);
      mem_load = (mem_op == OP_L);

      hit_ex   = ex_wr && ((src1 && (rs1 == ex_rd)) || (src2 && (rs2 == ex_rd)));
      hit_mem  = mem_load && ((src1 && (rs1 == mem_rd)) || (src2 && (rs2 == mem_rd)));

      need = 2'd0;
      if (id_valid) begin
         if (hit_ex && ex_load) begin
            need = id_br ? 2'(LOAD_BR_STALL) : 2'd1;
         end else if (hit_ex && id_br) begin
            need = 2'd1;
         end
         if (hit_mem && id_br && (need == 2'd0)) begin
            need = 2'd1;
         end
      end
   end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Stall/flush sequencer for the ID-resolved-branch pipeline, with saturating
// stall-cycle and flush performance counters.
module branch_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned LOAD_BR_STALL = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      id_inst,
   input  logic [31:0]      ex_inst,
   input  logic [31:0]      mem_inst,
   input  logic             id_valid,
   input  logic             br_taken,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_e           state_q, state_d;
   logic [1:0]       rem_q, rem_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [1:0]       need;
   logic [6:0]       id_op;
   logic             is_cf;
   logic             run_pc, run_flush;

   branch_dep_detect #(
      .LOAD_BR_STALL(LOAD_BR_STALL)
   ) u_dep (
      .id_inst (id_inst),
      .ex_inst (ex_inst),
      .mem_inst(mem_inst),
      .id_valid(id_valid),
      .need    (need)
   );

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      run_pc    = 1'b0;
      run_flush = 1'b0;
      id_op     = id_inst[6:0];
      is_cf     = (id_op == OP_B) || (id_op == OP_JAL) || (id_op == OP_JALR);

      case (state_q)
         ST_RUN: begin
            if (need == 2'd0) begin
               run_pc    = 1'b1;
               run_flush = br_taken && id_valid && is_cf;
            end else begin
               rem_d = need - 2'd1;
               if (need > 2'd1) state_d = ST_STALL;
            end
         end
         ST_STALL: begin
            rem_d = rem_q - 2'd1;
            if (rem_q <= 2'd1) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase

      // Reset forces the frozen/bubble pattern without waiting for a clock edge.
      pc_we       = rst_n && run_pc;
      ifid_we     = rst_n && run_pc;
      idex_bubble = !rst_n || !run_pc;
      ifid_flush  = rst_n && run_flush;

      stall_cnt_d = stall_cnt_q;
      if (!pc_we && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      flush_cnt_d = flush_cnt_q;
      if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         rem_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: directed scenarios plus random
// instruction streams checked against a rule-level reference model.
module tb_branch_hazard_ctrl;

   localparam int CNT_W = 6;
   localparam int LBS   = 2;
   localparam int MAXC  = (1 << CNT_W) - 1;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] LW_X5    = 32'h0000_A283;
   localparam logic [31:0] LW_X0    = 32'h0000_2003;
   localparam logic [31:0] ADD_X5   = 32'h0031_02B3;
   localparam logic [31:0] BEQ_X5X6 = 32'h0062_8063;
   localparam logic [31:0] ADD_X6X5 = 32'h0052_8333;
   localparam logic [31:0] ADD_X6X0 = 32'h0000_0333;

   localparam int K_X = 0, K_R = 1, K_B = 2, K_S = 3, K_I = 4, K_L = 5,
                  K_JAL = 6, K_JALR = 7, K_LUI = 8, K_AUIPC = 9;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [31:0]      id_inst = NOP, ex_inst = NOP, mem_inst = NOP;
   logic             id_valid = 1'b0, br_taken = 1'b0;
   logic             pc_we, ifid_we, ifid_flush, idex_bubble;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   int stall_left, m_stall, m_flush, cur_need;
   bit exp_pc, exp_flush;

   branch_hazard_ctrl #(
      .CNT_W        (CNT_W),
      .LOAD_BR_STALL(LBS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_inst    (id_inst),
      .ex_inst    (ex_inst),
      .mem_inst   (mem_inst),
      .id_valid   (id_valid),
      .br_taken   (br_taken),
      .pc_we      (pc_we),
      .ifid_we    (ifid_we),
      .ifid_flush (ifid_flush),
      .idex_bubble(idex_bubble),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int kind_of(input logic [6:0] op);
      case (op)
         7'h33:   return K_R;
         7'h63:   return K_B;
         7'h23:   return K_S;
         7'h13:   return K_I;
         7'h03:   return K_L;
         7'h6F:   return K_JAL;
         7'h67:   return K_JALR;
         7'h37:   return K_LUI;
         7'h17:   return K_AUIPC;
         default: return K_X;
      endcase
   endfunction

   function automatic int ref_need(input logic [31:0] id, input logic [31:0] ex,
                                   input logic [31:0] mem, input logic v);
      int ik, ek, mk, need;
      bit br, ex_wr;
      int srcs[$];
      ik = kind_of(id[6:0]);
      ek = kind_of(ex[6:0]);
      mk = kind_of(mem[6:0]);
      need = 0;
      if (!v) return 0;
      br = (ik == K_B) || (ik == K_JALR);
      if ((ik inside {K_R, K_B, K_S, K_I, K_L, K_JALR}) && (id[19:15] != 0))
         srcs.push_back(int'(id[19:15]));
      if ((ik inside {K_R, K_B, K_S}) && (id[24:20] != 0))
         srcs.push_back(int'(id[24:20]));
      ex_wr = ek inside {K_R, K_I, K_L, K_JAL, K_JALR, K_LUI, K_AUIPC};
      foreach (srcs[i]) begin
         if (ex_wr && srcs[i] == int'(ex[11:7])) begin
            if (ek == K_L) need = (br ? LBS : 1) > need ? (br ? LBS : 1) : need;
            else if (br && need < 1) need = 1;
         end
         if (mk == K_L && br && srcs[i] == int'(mem[11:7]) && need < 1) need = 1;
      end
      return need;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [6:0] ops [10];
      logic [4:0] rd, r1, r2;
      ops = '{7'h33, 7'h63, 7'h23, 7'h13, 7'h03, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
      rd = 5'($urandom_range(0, 3));
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      return {7'($urandom), r2, r1, 3'($urandom), rd, ops[$urandom_range(0, 9)]};
   endfunction

   task automatic model_reset();
      stall_left = 0;
      m_stall    = 0;
      m_flush    = 0;
   endtask

   task automatic model_eval();
      int k;
      k = kind_of(id_inst[6:0]);
      cur_need = 0;
      if (stall_left > 0) begin
         exp_pc = 0;
      end else begin
         cur_need = ref_need(id_inst, ex_inst, mem_inst, id_valid);
         exp_pc = (cur_need == 0);
      end
      exp_flush = exp_pc && br_taken && id_valid && (k == K_B || k == K_JAL || k == K_JALR);
   endtask

   task automatic model_tick();
      if (stall_left > 0) stall_left--;
      else if (cur_need > 0) stall_left = cur_need - 1;
      if (!exp_pc && m_stall < MAXC) m_stall++;
      if (exp_flush && m_flush < MAXC) m_flush++;
   endtask

   task automatic drive(input logic [31:0] id, input logic [31:0] ex,
                        input logic [31:0] mem, input logic v, input logic br);
      id_inst  = id;
      ex_inst  = ex;
      mem_inst = mem;
      id_valid = v;
      br_taken = br;
   endtask

   task automatic sample();
      @(negedge clk);
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      drive(NOP, NOP, NOP, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (pc_we !== 1'b0 || ifid_we !== 1'b0 || idex_bubble !== 1'b1 || ifid_flush !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got pc_we=%b ifid_we=%b bubble=%b flush=%b exp 0 0 1 0",
                  pc_we, ifid_we, idex_bubble, ifid_flush);
      end
      checks++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin
         errors++;
         $display("FAIL reset_cnt got stall=%0d flush=%0d exp 0 0", stall_cnt, flush_cnt);
      end
      rst_n = 1'b1;
      model_eval();
      advance();
      sample();
      checks++;
      if (pc_we !== 1'b1 || ifid_we !== 1'b1 || idex_bubble !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got pc_we=%b ifid_we=%b bubble=%b exp 1 1 0",
                  pc_we, ifid_we, idex_bubble);
      end
      advance();
   endtask

   task automatic test_load_branch();
      drive(BEQ_X5X6, LW_X5, NOP, 1'b1, 1'b0);
      sample();
      checks++;
      if (pc_we !== 1'b0 || idex_bubble !== 1'b1) begin
         errors++;
         $display("FAIL ldbr_stall0 got pc_we=%b bubble=%b exp 0 1", pc_we, idex_bubble);
      end
      advance();
      drive(BEQ_X5X6, NOP, LW_X5, 1'b1, 1'b0);
      sample();
      checks++;
      if (pc_we !== 1'b0 || ifid_we !== 1'b0) begin
         errors++;
         $display("FAIL ldbr_stall1 got pc_we=%b ifid_we=%b exp 0 0", pc_we, ifid_we);
      end
      advance();
      drive(BEQ_X5X6, NOP, NOP, 1'b1, 1'b0);
      sample();
      checks++;
      if (pc_we !== 1'b1 || stall_cnt !== CNT_W'(2)) begin
         errors++;
         $display("FAIL ldbr_release got pc_we=%b stall_cnt=%0d exp 1 2", pc_we, stall_cnt);
      end
      advance();
   endtask

   task automatic test_alu_branch();
      drive(BEQ_X5X6, ADD_X5, NOP, 1'b1, 1'b0);
      sample();
      checks++;
      if (pc_we !== 1'b0 || ifid_flush !== 1'b0) begin
         errors++;
         $display("FAIL alubr_stall got pc_we=%b flush=%b exp 0 0", pc_we, ifid_flush);
      end
      advance();
      drive(BEQ_X5X6, NOP, ADD_X5, 1'b1, 1'b0);
      sample();
      checks++;
      if (pc_we !== 1'b1 || ifid_flush !== 1'b0 || stall_cnt !== CNT_W'(3)) begin
         errors++;
         $display("FAIL alubr_release got pc_we=%b flush=%b stall_cnt=%0d exp 1 0 3",
                  pc_we, ifid_flush, stall_cnt);
      end
      advance();
   endtask

   task automatic test_load_alu();
      drive(ADD_X6X5, LW_X5, NOP, 1'b1, 1'b0);
      sample();
      checks++;
      if (pc_we !== 1'b0) begin
         errors++;
         $display("FAIL ldalu_stall got pc_we=%b exp 0", pc_we);
      end
      advance();
      drive(ADD_X6X5, NOP, LW_X5, 1'b1, 1'b0);
      sample();
      checks++;
      if (pc_we !== 1'b1) begin
         errors++;
         $display("FAIL ldalu_release got pc_we=%b exp 1", pc_we);
      end
      advance();
      drive(ADD_X6X0, LW_X0, NOP, 1'b1, 1'b0);
      sample();
      checks++;
      if (pc_we !== 1'b1 || idex_bubble !== 1'b0) begin
         errors++;
         $display("FAIL ldalu_x0 got pc_we=%b bubble=%b exp 1 0", pc_we, idex_bubble);
      end
      advance();
   endtask

   task automatic test_flush();
      drive(BEQ_X5X6, NOP, NOP, 1'b1, 1'b1);
      sample();
      checks++;
      if (ifid_flush !== 1'b1 || pc_we !== 1'b1) begin
         errors++;
         $display("FAIL flush_pulse got flush=%b pc_we=%b exp 1 1", ifid_flush, pc_we);
      end
      advance();
      drive(NOP, NOP, NOP, 1'b1, 1'b1);
      sample();
      checks++;
      if (ifid_flush !== 1'b0 || flush_cnt !== CNT_W'(1)) begin
         errors++;
         $display("FAIL flush_end got flush=%b flush_cnt=%0d exp 0 1", ifid_flush, flush_cnt);
      end
      advance();
      drive(BEQ_X5X6, LW_X5, NOP, 1'b1, 1'b1);
      sample();
      checks++;
      if (ifid_flush !== 1'b0 || pc_we !== 1'b0) begin
         errors++;
         $display("FAIL flush_stall0 got flush=%b pc_we=%b exp 0 0", ifid_flush, pc_we);
      end
      advance();
      drive(BEQ_X5X6, NOP, LW_X5, 1'b1, 1'b1);
      sample();
      checks++;
      if (ifid_flush !== 1'b0 || pc_we !== 1'b0) begin
         errors++;
         $display("FAIL flush_stall1 got flush=%b pc_we=%b exp 0 0", ifid_flush, pc_we);
      end
      advance();
      drive(BEQ_X5X6, NOP, NOP, 1'b1, 1'b1);
      sample();
      checks++;
      if (ifid_flush !== 1'b1 || pc_we !== 1'b1) begin
         errors++;
         $display("FAIL flush_after_stall got flush=%b pc_we=%b exp 1 1", ifid_flush, pc_we);
      end
      advance();
      drive(NOP, NOP, NOP, 1'b1, 1'b0);
      sample();
      checks++;
      if (flush_cnt !== CNT_W'(2)) begin
         errors++;
         $display("FAIL flush_cnt got %0d exp 2", flush_cnt);
      end
      advance();
   endtask

   task automatic test_reset_mid_stall();
      drive(BEQ_X5X6, LW_X5, NOP, 1'b1, 1'b0);
      sample();
      advance();
      drive(BEQ_X5X6, NOP, LW_X5, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (pc_we !== 1'b0 || ifid_we !== 1'b0 || idex_bubble !== 1'b1 || ifid_flush !== 1'b0 ||
          stall_cnt !== '0 || flush_cnt !== '0) begin
         errors++;
         $display("FAIL async_reset got pc_we=%b ifid_we=%b bubble=%b flush=%b sc=%0d fc=%0d exp 0 0 1 0 0 0",
                  pc_we, ifid_we, idex_bubble, ifid_flush, stall_cnt, flush_cnt);
      end
      model_reset();
      drive(NOP, NOP, NOP, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      model_eval();
      #1;
      checks++;
      if (pc_we !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_run got pc_we=%b exp 1", pc_we);
      end
      advance();
      sample();
      checks++;
      if (pc_we !== 1'b1 || stall_cnt !== '0) begin
         errors++;
         $display("FAIL post_reset_nopend got pc_we=%b stall_cnt=%0d exp 1 0", pc_we, stall_cnt);
      end
      advance();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(rand_inst(), rand_inst(), rand_inst(), ($urandom_range(0, 7) != 0),
               1'($urandom));
         sample();
         checks++;
         if (pc_we !== exp_pc || ifid_we !== exp_pc || idex_bubble !== !exp_pc ||
             ifid_flush !== exp_flush) begin
            errors++;
            $display("FAIL rand_ctrl[%0d] got pc=%b ifid=%b bub=%b fl=%b exp pc=%b fl=%b id=%h ex=%h mem=%h",
                     n, pc_we, ifid_we, idex_bubble, ifid_flush, exp_pc, exp_flush,
                     id_inst, ex_inst, mem_inst);
         end
         checks++;
         if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
            errors++;
            $display("FAIL rand_cnt[%0d] got stall=%0d flush=%0d exp %0d %0d",
                     n, stall_cnt, flush_cnt, m_stall, m_flush);
         end
         advance();
      end
   endtask

   task automatic test_saturation();
      int runs;
      runs = 0;
      drive(BEQ_X5X6, LW_X5, NOP, 1'b1, 1'b1);
      for (int n = 0; n < 80; n++) begin
         sample();
         if (pc_we !== 1'b0) runs++;
         advance();
      end
      checks++;
      if (runs != 0) begin
         errors++;
         $display("FAIL residual_stall got %0d unstalled cycles exp 0", runs);
      end
      sample();
      checks++;
      if (stall_cnt !== CNT_W'(MAXC) || stall_cnt !== CNT_W'(m_stall)) begin
         errors++;
         $display("FAIL stall_sat got %0d exp %0d", stall_cnt, MAXC);
      end
      advance();
      drive(BEQ_X5X6, NOP, NOP, 1'b1, 1'b1);
      for (int n = 0; n < 80; n++) begin
         sample();
         advance();
      end
      sample();
      checks++;
      if (flush_cnt !== CNT_W'(MAXC) || stall_cnt !== CNT_W'(MAXC) || ifid_flush !== 1'b1) begin
         errors++;
         $display("FAIL flush_sat got flush_cnt=%0d stall_cnt=%0d flush=%b exp %0d %0d 1",
                  flush_cnt, stall_cnt, ifid_flush, MAXC, MAXC);
      end
      advance();
   endtask

   initial begin
      test_reset();
      test_load_branch();
      test_alu_branch();
      test_load_alu();
      test_flush();
      test_reset_mid_stall();
      test_random();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
